eprom_ctrl: RTL

Command sequencer for the 16x8 EPROM array. Accepts read, program, erase and blank-check commands over a valid/ready interface, drives the array's address, data, write-enable and erase lines, and enforces EPROM semantics:
- bits may only be programmed 1->0;
- program pulses are timed, then verified, with retries;
- erase is a timed pulse followed by a blank scan.

One response is returned per command.

---
 rtl/eprom_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/eprom_ctrl.sv
`timescale 1ns/1ps
// eprom_ctrl
// Command sequencer for a 16x8 EPROM array. Accepts read, program, erase and
// blank-check commands on a valid/ready handshake, drives the array control
// lines and returns exactly one response per command.
//
// Build option: EPROM_CTRL_ERASE_VERIFY_EN
//   defined   -> erase is followed by a 16-address blank scan
//   undefined -> erase responds directly after the erase pulse (err=0, data=00)
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready only in IDLE)
//   cmd_op[1:0]               00 read, 01 program, 10 erase, 11 blank-check
//   cmd_addr[3:0], cmd_data   word address and program data
//   rsp_valid/rsp_ready       response handshake
//   rsp_data[7:0], rsp_err    result and failure flag
//   busy                      command in progress or response pending
//   mem_addr, mem_din         array address / write data
//   mem_we, mem_erase         array program / erase strobes
//   mem_data[7:0]             array combinational read data
module eprom_ctrl #(
    parameter int PROG_PULSE  = 2,
    parameter int ERASE_PULSE = 4,
    parameter int MAX_TRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic       mem_erase,
    input  logic [7:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE, READ, PCHECK, PROG, PVERIFY, ERASE, BLANK, RESP
    } state_t;

    state_t      state, state_n;
    logic [3:0]  addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] try_q, try_n;
    logic        blank_fail, blank_fail_n;
    logic [3:0]  first_addr, first_addr_n;
    logic [7:0]  rsp_data_q, rsp_data_n;
    logic        rsp_err_q, rsp_err_n;
    logic        scan_fail;
    logic [3:0]  scan_first;

    // State and datapath registers; reset clears everything so the array
    // strobes, which decode from state, drop as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= 4'h0;
            data_q     <= 8'h00;
            cnt        <= 16'd0;
            try_q      <= 16'd0;
            blank_fail <= 1'b0;
            first_addr <= 4'h0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            cnt        <= cnt_n;
            try_q      <= try_n;
            blank_fail <= blank_fail_n;
            first_addr <= first_addr_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
        end
    end

    // Blank-scan result including the address being read this cycle, so the
    // final scan cycle can produce the response without an extra state.
    always_comb begin
        scan_fail  = blank_fail | (mem_data != 8'hFF);
        scan_first = blank_fail ? first_addr : cnt[3:0];
    end

    // Next-state logic and sequencing of counters and response registers.
    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        data_n       = data_q;
        cnt_n        = cnt;
        try_n        = try_q;
        blank_fail_n = blank_fail;
        first_addr_n = first_addr;
        rsp_data_n   = rsp_data_q;
        rsp_err_n    = rsp_err_q;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_n       = cmd_addr;
                    data_n       = cmd_data;
                    cnt_n        = 16'd0;
                    try_n        = 16'd0;
                    blank_fail_n = 1'b0;
                    first_addr_n = 4'h0;
                    case (cmd_op)
                        2'b00:   state_n = READ;
                        2'b01:   state_n = PCHECK;
                        2'b10:   state_n = ERASE;
                        default: state_n = BLANK;
                    endcase
                end
            end
            READ: begin
                rsp_data_n = mem_data;
                rsp_err_n  = 1'b0;
                state_n    = RESP;
            end
            PCHECK: begin
                // Any bit that would need a 0->1 transition cannot be programmed.
                if ((~mem_data & data_q) != 8'h00) begin
                    rsp_data_n = mem_data;
                    rsp_err_n  = 1'b1;
                    state_n    = RESP;
                end else begin
                    cnt_n   = 16'd0;
                    state_n = PROG;
                end
            end
            PROG: begin
                if (cnt == 16'(PROG_PULSE - 1)) begin
                    cnt_n   = 16'd0;
                    try_n   = try_q + 16'd1;
                    state_n = PVERIFY;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            PVERIFY: begin
                if (mem_data == data_q) begin
                    rsp_data_n = mem_data;
                    rsp_err_n  = 1'b0;
                    state_n    = RESP;
                end else if (try_q < 16'(MAX_TRY)) begin
                    cnt_n   = 16'd0;
                    state_n = PROG;
                end else begin
                    rsp_data_n = mem_data;
                    rsp_err_n  = 1'b1;
                    state_n    = RESP;
                end
            end
            ERASE: begin
                if (cnt == 16'(ERASE_PULSE - 1)) begin
                    cnt_n = 16'd0;
`ifdef EPROM_CTRL_ERASE_VERIFY_EN
                    blank_fail_n = 1'b0;
                    first_addr_n = 4'h0;
                    state_n      = BLANK;
`else
                    rsp_data_n = 8'h00;
                    rsp_err_n  = 1'b0;
                    state_n    = RESP;
`endif
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            BLANK: begin
                // Always scans all 16 words so latency does not depend on content.
                cnt_n        = cnt + 16'd1;
                blank_fail_n = scan_fail;
                first_addr_n = scan_first;
                if (cnt == 16'd15) begin
                    cnt_n      = 16'd0;
                    rsp_err_n  = scan_fail;
                    rsp_data_n = scan_fail ? {4'h0, scan_first} : 8'h00;
                    state_n    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake and array-side outputs decode directly from registered state.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        mem_we    = (state == PROG);
        mem_erase = (state == ERASE);
        mem_din   = (state == PROG) ? data_q : 8'h00;
        case (state)
            READ, PCHECK, PROG, PVERIFY: mem_addr = addr_q;
            BLANK:                       mem_addr = cnt[3:0];
            default:                     mem_addr = 4'h0;
        endcase
    end

endmodule
